// File: rtl/memory_bus_pkg.sv
// Shared decode constants and UART encoding for the memory_bus slave.
// Used by memory_bus and by uart_tx_core (present only when UART_TX_EN is defined).
package memory_bus_pkg;

   localparam int IO_SEL_BIT = 22;

   localparam logic [1:0] IO_LEDS        = 2'd0;
   localparam logic [1:0] IO_UART_DATA   = 2'd1;
   localparam logic [1:0] IO_UART_STATUS = 2'd2;

   localparam int UART_BUSY_BIT   = 9;
   localparam int UART_FRAME_BITS = 10;

   typedef enum logic {
      UART_IDLE = 1'b0,
      UART_SEND = 1'b1
   } uart_state_t;

endpackage

// File: rtl/memory_bus_uart_tx.sv
// uart_tx_core: 8N1 serial transmitter. Sends one frame per start pulse and
// ignores start while a frame is in flight.
module uart_tx_core
   import memory_bus_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data,
   output logic       busy,
   output logic       tx
);

   localparam int CW = $clog2(CLKS_PER_BIT);

   uart_state_t                r_state;
   uart_state_t                w_next_state;
   logic [UART_FRAME_BITS-1:0] r_frame;
   logic [3:0]                 r_bit_cnt;
   logic [CW-1:0]              r_clk_cnt;
   logic                       w_tick;
   logic                       w_last_bit;

   assign w_tick     = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
   assign w_last_bit = (r_bit_cnt == 4'(UART_FRAME_BITS - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= UART_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      busy         = 1'b0;
      tx           = 1'b1;
      case (r_state)
         UART_IDLE: begin
            if (start) w_next_state = UART_SEND;
         end
         UART_SEND: begin
            busy = 1'b1;
            tx   = r_frame[0];
            if (w_tick && w_last_bit) w_next_state = UART_IDLE;
         end
         default: w_next_state = UART_IDLE;
      endcase
   end

   // Frame shifts out LSB first; stop bit is refilled from the top.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_frame   <= '1;
         r_bit_cnt <= '0;
         r_clk_cnt <= '0;
      end else if (r_state == UART_IDLE) begin
         if (start) begin
            r_frame   <= {1'b1, data, 1'b0};
            r_bit_cnt <= '0;
            r_clk_cnt <= '0;
         end
      end else if (w_tick) begin
         r_frame   <= {1'b1, r_frame[UART_FRAME_BITS-1:1]};
         r_bit_cnt <= r_bit_cnt + 4'd1;
         r_clk_cnt <= '0;
      end else begin
         r_clk_cnt <= r_clk_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/memory_bus.sv
// memory_bus: fixed 1-cycle-latency RAM + IO slave for the RV32I core.
// Optional UART transmitter is built only when the macro UART_TX_EN is defined.
module memory_bus
   import memory_bus_pkg::*;
#(
   parameter int MEM_WORDS    = 1024,
   parameter     INIT_FILE    = "",
   parameter int LEDS_W       = 5,
   parameter int CLKS_PER_BIT = 868
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       mem_addr,
   input  logic              mem_rstrb,
   output logic [31:0]       mem_rdata,
   input  logic [31:0]       mem_wdata,
   input  logic [3:0]        mem_wmask,
   output logic [LEDS_W-1:0] leds,
   output logic              uart_tx
);

   localparam int AW = $clog2(MEM_WORDS);

   logic [31:0]       r_mem [0:MEM_WORDS-1];
   logic [31:0]       r_rdata;
   logic [LEDS_W-1:0] r_leds;

   logic              w_io_sel;
   logic [AW-1:0]     w_idx;
   logic [1:0]        w_io_idx;
   logic              w_wr;
   logic [31:0]       w_io_rdata;
   logic [31:0]       w_rdata;
   logic              w_uart_busy;
   logic              w_unused;

   assign w_io_sel = mem_addr[IO_SEL_BIT];
   assign w_idx    = mem_addr[AW+1:2];
   assign w_io_idx = mem_addr[3:2];
   assign w_wr     = |mem_wmask;
   assign w_unused = ^{mem_addr, mem_wdata};

   // Reset blocks RAM writes too; RAM contents themselves are never cleared.
   always_ff @(posedge clk) begin
      if (reset && w_wr && !w_io_sel) begin
         for (int k = 0; k < 4; k++) begin
            if (mem_wmask[k]) r_mem[w_idx][8*k +: 8] <= mem_wdata[8*k +: 8];
         end
      end
   end

   always_comb begin
      w_io_rdata = '0;
      case (w_io_idx)
         IO_LEDS:        w_io_rdata[LEDS_W-1:0]     = r_leds;
         IO_UART_STATUS: w_io_rdata[UART_BUSY_BIT] = w_uart_busy;
         default:        w_io_rdata = '0;
      endcase
   end

   assign w_rdata = w_io_sel ? w_io_rdata : r_mem[w_idx];

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rdata <= '0;
         r_leds  <= '0;
      end else begin
         if (mem_rstrb) r_rdata <= w_rdata;
         if (w_wr && w_io_sel && (w_io_idx == IO_LEDS)) r_leds <= mem_wdata[LEDS_W-1:0];
      end
   end

   assign mem_rdata = r_rdata;
   assign leds      = r_leds;

`ifdef UART_TX_EN
   logic w_uart_start;

   assign w_uart_start = w_wr && w_io_sel && (w_io_idx == IO_UART_DATA);

   uart_tx_core #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart (
      .clk  (clk),
      .reset(reset),
      .start(w_uart_start),
      .data (mem_wdata[7:0]),
      .busy (w_uart_busy),
      .tx   (uart_tx)
   );
`else
   logic w_unused_cfg;

   assign w_unused_cfg = (CLKS_PER_BIT >= 2);
   assign w_uart_busy  = 1'b0;
   assign uart_tx      = 1'b1;
`endif

endmodule

// File: tb/tb_memory_bus.sv
// Directed bench for memory_bus with a cycle-level reference model of the
// RAM, LED register and UART line, plus literal expectations.
module tb_memory_bus;

   localparam int MW  = 64;
   localparam int CPB = 4;
   localparam int LW  = 5;
   localparam int FB  = 10;
`ifdef UART_TX_EN
   localparam bit UART_EN = 1'b1;
`else
   localparam bit UART_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   addr;
   logic          rstrb;
   logic [31:0]   rdata;
   logic [31:0]   wdata;
   logic [3:0]    wmask;
   logic [LW-1:0] leds;
   logic          tx;

   int n_err = 0;
   int n_chk = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   memory_bus #(
      .MEM_WORDS(MW), .INIT_FILE(""), .LEDS_W(LW), .CLKS_PER_BIT(CPB)
   ) dut (
      .clk(clk), .reset(rst_n), .mem_addr(addr), .mem_rstrb(rstrb),
      .mem_rdata(rdata), .mem_wdata(wdata), .mem_wmask(wmask),
      .leds(leds), .uart_tx(tx)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0]   m_mem [MW];
   bit            m_val [MW];
   logic [31:0]   m_rd = '0;
   bit            m_rd_known = 1'b0;
   logic [LW-1:0] m_leds = '0;
   bit            m_act = 1'b0;
   int            m_start = 0;
   logic [9:0]    m_frame = '1;
   int            k = 0;

   function automatic bit m_busy_at(int c);
      return m_act && (c >= m_start) && (c - m_start < FB * CPB);
   endfunction

   function automatic logic m_tx_at(int c);
      return m_busy_at(c) ? m_frame[(c - m_start) / CPB] : 1'b1;
   endfunction

   always @(posedge clk) begin
      int idx;
      idx = int'(addr[7:2]);
      if (!rst_n) begin
         m_rd = '0; m_rd_known = 1'b1; m_leds = '0; m_act = 1'b0;
      end else begin
         if (rstrb) begin
            if (addr[22]) begin
               m_rd_known = 1'b1;
               case (addr[3:2])
                  2'd0:    m_rd = {27'b0, m_leds};
                  2'd2:    m_rd = m_busy_at(k) ? 32'h0000_0200 : 32'h0;
                  default: m_rd = 32'h0;
               endcase
            end else begin
               m_rd = m_mem[idx];
               m_rd_known = m_val[idx];
            end
         end
         if (wmask != 4'h0) begin
            if (!addr[22]) begin
               for (int b = 0; b < 4; b++)
                  if (wmask[b]) m_mem[idx][8*b +: 8] = wdata[8*b +: 8];
               m_val[idx] = m_val[idx] || (wmask == 4'hF);
            end else if (addr[3:2] == 2'd0) begin
               m_leds = wdata[LW-1:0];
            end else if (addr[3:2] == 2'd1 && UART_EN && !m_busy_at(k)) begin
               m_act = 1'b1; m_start = k + 1; m_frame = {1'b1, wdata[7:0], 1'b0};
            end
         end
      end
      k = k + 1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         if (m_rd_known) chk("rdata_model", rdata, m_rd);
         chk("leds_model", {27'b0, leds}, {27'b0, m_leds});
         chk("uart_tx_model", {31'b0, tx}, {31'b0, m_tx_at(k)});
      end
   end

   // ---------------- stimulus ----------------
   task automatic bus(input logic [31:0] a, input logic rs, input logic [31:0] wd, input logic [3:0] wm);
      addr = a; rstrb = rs; wdata = wd; wmask = wm;
      @(negedge clk);
   endtask
   task automatic idle();                                         bus(32'h0, 1'b0, 32'h0, 4'h0); endtask
   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m); bus(a, 1'b0, d, m); endtask
   task automatic rd(input logic [31:0] a);                        bus(a, 1'b1, 32'h0, 4'h0); endtask

   function automatic logic exp_bit(input logic [9:0] pat, input int j);
      return (UART_EN && j < FB * CPB) ? pat[j / CPB] : 1'b1;
   endfunction

   task automatic frame_check(input string nm, input logic [9:0] pat, input bit poke);
      for (int j = 0; j < 44; j++) begin
         chk(nm, {31'b0, tx}, {31'b0, exp_bit(pat, j)});
         if (poke && j == 5) begin
            rd(32'h0040_0008);
            chk("status_busy", rdata, UART_EN ? 32'h0000_0200 : 32'h0);
         end else if (poke && j == 12) begin
            wr(32'h0040_0004, 32'h0000_003C, 4'hF);
         end else begin
            idle();
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; addr = '0; rstrb = 1'b0; wdata = '0; wmask = '0;
      @(negedge clk);
      idle(); idle(); idle();
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_leds", {27'b0, leds}, 32'h0);
      chk("reset_tx", {31'b0, tx}, 32'h1);
      rst_n = 1'b1;
      chk_en = 1'b1;

      wr(32'h0, 32'h0050_0093, 4'hF);
      rd(32'h0);
      chk("word0_read", rdata, 32'h0050_0093);
      idle(); idle(); idle();
      chk("word0_hold", rdata, 32'h0050_0093);

      wr(32'h10, 32'hAABB_CCDD, 4'hF);
      wr(32'h10, 32'h0000_0011, 4'b0001);
      rd(32'h10);
      chk("byte_mask", rdata, 32'hAABB_CC11);
      rd(32'h10 + MW * 4);
      chk("alias", rdata, 32'hAABB_CC11);
      wr(32'h10, 32'h5566_7788, 4'b1010);
      rd(32'h10);
      chk("mask_1010", rdata, 32'h55BB_7711);

      wr(32'h20, 32'h0, 4'hF);
      bus(32'h20, 1'b1, 32'h1234_5678, 4'hF);
      chk("rbw_old", rdata, 32'h0);
      rd(32'h20);
      chk("rbw_new", rdata, 32'h1234_5678);

      wr(32'h0040_0000, 32'h0000_001F, 4'h1);
      chk("leds_set", {27'b0, leds}, 32'h1F);
      rd(32'h0040_0000);
      chk("leds_read", rdata, 32'h0000_001F);
      wr(32'h0040_000C, 32'hFFFF_FFFF, 4'hF);
      rd(32'h0040_000C);
      chk("reserved_read", rdata, 32'h0);
      rd(32'h0040_0000);
      rd(32'h0040_0004);
      chk("uart_data_read", rdata, 32'h0);
      rd(32'h0040_0000);
      rst_n = 1'b0;
      wr(32'h0040_0000, 32'h0000_0003, 4'hF);
      rst_n = 1'b1;
      chk("reset_leds2", {27'b0, leds}, 32'h0);
      chk("reset_rdata2", rdata, 32'h0);

      wr(32'h0040_0004, 32'h0000_00A5, 4'hF);
      frame_check("frame_A5", 10'b1_1010_0101_0, 1'b1);
      rd(32'h0040_0008);
      chk("status_idle", rdata, 32'h0);

      wr(32'h0040_0004, 32'h0000_00FF, 4'hF);
      repeat (10) idle();
      rst_n = 1'b0;
      idle();
      rst_n = 1'b1;
      chk("midframe_reset_tx", {31'b0, tx}, 32'h1);
      rd(32'h0040_0008);
      chk("midframe_reset_busy", rdata, 32'h0);
      wr(32'h0040_0004, 32'h0000_0000, 4'hF);
      frame_check("frame_00", 10'b1_0000_0000_0, 1'b0);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
